// File: rtl/mem_ctrler.sv
// mem_ctrler: byte-wide RAM bus sequencer shared between the instruction
// fetcher (cache-line reads) and the load-store buffer (1/2/4-byte accesses).
// Each granted request is split into per-byte RAM cycles. Multi-byte data is
// little-endian, and completion is a one-cycle ready pulse.
// Optional feature: define MEM_CTRLER_IO_STALL_EN to hold writes to the
// 0x0003xxxx I/O window while io_buffer_full is high.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates fetcher vs LSB
// READ  | issuing byte addresses and capturing mem_din one cycle later
// WRITE | issuing one store byte per cycle with mem_wr high
// DONE  | one-cycle ready pulse to the granted requester
module mem_ctrler #(
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    valid_from_inst_fetcher,
  input  logic [31:0]             addr_from_inst_fetcher,
  output logic                    ready_to_inst_fetcher,
  output logic [LINE_BYTES*8-1:0] cache_line_to_inst_fetcher,
  input  logic                    valid_from_lsb,
  input  logic                    is_write_from_lsb,
  input  logic [31:0]             addr_from_lsb,
  input  logic [1:0]              len_from_lsb,
  input  logic [31:0]             data_from_lsb,
  output logic                    ready_to_lsb,
  output logic [31:0]             data_to_lsb
);

  localparam int CW = $clog2(LINE_BYTES + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                  state;
  logic                    owner_lsb;
  logic                    last_grant_lsb;
  logic                    wr_q;
  logic                    rd_pend;
  logic                    all_cap;
  logic [CW-1:0]           n_bytes;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           rd_idx;
  logic [CW-1:0]           lsb_n;
  logic [23:0]             wdata;
  logic [LINE_BYTES*8-1:0] line_buf;
  logic [LINE_BYTES*8-1:0] next_buf;
  logic                    grant_any;
  logic                    grant_lsb;
  logic                    stall;

  // Arbitration: round-robin on a tie, flush cycles ignore requests.
  always_comb begin
    grant_any = !flush && (valid_from_inst_fetcher || valid_from_lsb);
    grant_lsb = valid_from_lsb && (!valid_from_inst_fetcher || !last_grant_lsb);
    case (len_from_lsb)
      2'd0:    lsb_n = CW'(1);
      2'd1:    lsb_n = CW'(2);
      default: lsb_n = CW'(4);
    endcase
  end

  // Line buffer with the byte arriving this cycle merged in, so the DONE
  // outputs can be loaded on the same edge as the final capture.
  always_comb begin
    next_buf = line_buf;
    for (int k = 0; k < LINE_BYTES; k++) begin
      if (rd_pend && rd_idx == CW'(k)) next_buf[8*k +: 8] = mem_din;
    end
  end

`ifdef MEM_CTRLER_IO_STALL_EN
  assign stall = (state == WRITE) && io_buffer_full && (mem_a[31:16] == 16'h0003);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign stall     = 1'b0;
`endif

  assign mem_wr = wr_q & rdy & ~stall;

  // Main sequencer. Read data is captured even while rdy is low so that a
  // byte already in flight on mem_din is not lost across a freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      owner_lsb                  <= 1'b0;
      last_grant_lsb             <= 1'b0;
      wr_q                       <= 1'b0;
      rd_pend                    <= 1'b0;
      all_cap                    <= 1'b0;
      n_bytes                    <= '0;
      cnt                        <= '0;
      rd_idx                     <= '0;
      wdata                      <= '0;
      line_buf                   <= '0;
      mem_a                      <= '0;
      mem_dout                   <= '0;
      ready_to_inst_fetcher      <= 1'b0;
      ready_to_lsb               <= 1'b0;
      cache_line_to_inst_fetcher <= '0;
      data_to_lsb                <= '0;
    end else begin
      rd_pend <= 1'b0;
      if (rd_pend) begin
        line_buf <= next_buf;
        if (rd_idx == n_bytes - CW'(1)) all_cap <= 1'b1;
      end
      if (rdy) begin
        case (state)
          IDLE: begin
            if (grant_any) begin
              owner_lsb      <= grant_lsb;
              last_grant_lsb <= grant_lsb;
              cnt            <= '0;
              all_cap        <= 1'b0;
              line_buf       <= '0;
              if (grant_lsb) begin
                n_bytes <= lsb_n;
                mem_a   <= addr_from_lsb;
                wdata   <= data_from_lsb[31:8];
                if (is_write_from_lsb) begin
                  state    <= WRITE;
                  wr_q     <= 1'b1;
                  mem_dout <= data_from_lsb[7:0];
                end else begin
                  state <= READ;
                end
              end else begin
                n_bytes <= CW'(LINE_BYTES);
                mem_a   <= addr_from_inst_fetcher;
                state   <= READ;
              end
            end
          end
          READ: begin
            if (flush) begin
              state <= IDLE;
              mem_a <= '0;
              cnt   <= '0;
            end else begin
              if (cnt < n_bytes) begin
                rd_pend <= 1'b1;
                rd_idx  <= cnt;
                cnt     <= cnt + CW'(1);
                mem_a   <= (cnt == n_bytes - CW'(1)) ? 32'd0 : mem_a + 32'd1;
              end
              if ((rd_pend && rd_idx == n_bytes - CW'(1)) || all_cap) begin
                state <= DONE;
                if (owner_lsb) begin
                  data_to_lsb  <= next_buf[31:0];
                  ready_to_lsb <= 1'b1;
                end else begin
                  cache_line_to_inst_fetcher <= next_buf;
                  ready_to_inst_fetcher      <= 1'b1;
                end
              end
            end
          end
          WRITE: begin
            if (!stall) begin
              if (cnt == n_bytes - CW'(1)) begin
                state        <= DONE;
                wr_q         <= 1'b0;
                mem_a        <= '0;
                mem_dout     <= '0;
                ready_to_lsb <= 1'b1;
              end else begin
                cnt      <= cnt + CW'(1);
                mem_a    <= mem_a + 32'd1;
                mem_dout <= wdata[7:0];
                wdata    <= {8'h00, wdata[23:8]};
              end
            end
          end
          default: begin
            state                 <= IDLE;
            ready_to_inst_fetcher <= 1'b0;
            ready_to_lsb          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
